// File: rtl/pc_ctrl_pkg.sv
// Shared types and default parameters for the fetch-side PC controller.
package pc_ctrl_pkg;

  localparam int PCC_DATA_WIDTH_DEF = 32;
  localparam int PCC_PC_INC_DEF     = 4;
  localparam int PCC_DRAIN_DEF      = 4;
  localparam int PCC_CNT_W          = 4;

  typedef enum logic [1:0] {
    PCC_RUN    = 2'd0,
    PCC_DRAIN  = 2'd1,
    PCC_HALTED = 2'd2,
    PCC_STEP   = 2'd3
  } pcc_state_e;

  typedef enum logic {
    REDIR_ID = 1'b0,
    REDIR_EX = 1'b1
  } redir_src_e;

endpackage

// File: rtl/pc_redirect_arb.sv
// Priority selection between EX branches, a held redirect and ID jumps,
// plus the register that holds a redirect until the fetch port is ready.
module pc_redirect_arb
  import pc_ctrl_pkg::*;
#(
  parameter int W = PCC_DATA_WIDTH_DEF
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         enable_i,
  input  logic         if_ready_i,
  input  logic         stall_i,
  input  logic         ex_branch_i,
  input  logic [W-1:0] ex_target_i,
  input  logic         id_jump_i,
  input  logic [W-1:0] id_target_i,
  output logic         take_branch_o,
  output logic [W-1:0] branch_target_o,
  output logic         ex_event_o,
  output logic         id_event_o
);

  logic         pend_valid_q, pend_valid_d;
  logic [W-1:0] pend_target_q, pend_target_d;
  redir_src_e   pend_src_q, pend_src_d;
  logic         id_ok;

  assign id_ok = id_jump_i & ~stall_i;

  always_comb begin
    take_branch_o   = 1'b0;
    branch_target_o = pend_target_q;
    ex_event_o      = 1'b0;
    id_event_o      = 1'b0;
    pend_valid_d    = pend_valid_q;
    pend_target_d   = pend_target_q;
    pend_src_d      = pend_src_q;
    if (enable_i) begin
      if (ex_branch_i) begin
        ex_event_o = 1'b1;
        if (if_ready_i) begin
          take_branch_o   = 1'b1;
          branch_target_o = ex_target_i;
          pend_valid_d    = 1'b0;
        end else begin
          pend_valid_d  = 1'b1;
          pend_target_d = ex_target_i;
          pend_src_d    = REDIR_EX;
        end
      end else if (pend_valid_q) begin
        if (if_ready_i) begin
          take_branch_o   = 1'b1;
          branch_target_o = pend_target_q;
          pend_valid_d    = 1'b0;
        end else if (id_ok && pend_src_q == REDIR_ID) begin
          // A newer ID jump may replace an older held ID jump, never an EX one.
          id_event_o    = 1'b1;
          pend_target_d = id_target_i;
        end
      end else if (id_ok) begin
        id_event_o = 1'b1;
        if (if_ready_i) begin
          take_branch_o   = 1'b1;
          branch_target_o = id_target_i;
        end else begin
          pend_valid_d  = 1'b1;
          pend_target_d = id_target_i;
          pend_src_d    = REDIR_ID;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      pend_src_q    <= REDIR_ID;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      pend_src_q    <= pend_src_d;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-side PC sequencer: sequential fetch, redirect steering, flush strobes
// and the run/drain/halted/single-step control state machine.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = PCC_DATA_WIDTH_DEF,
  parameter int PC_INC       = PCC_PC_INC_DEF,
  parameter int DRAIN_CYCLES = PCC_DRAIN_DEF
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  if_ready_i,
  input  logic                  stall_i,
  input  logic                  id_jump_i,
  input  logic [DATA_WIDTH-1:0] id_jump_target_i,
  input  logic                  ex_branch_i,
  input  logic [DATA_WIDTH-1:0] ex_branch_target_i,
  input  logic                  halt_req_i,
  input  logic                  dbg_step_i,
  input  logic                  dbg_resume_i,
  output logic [DATA_WIDTH-1:0] next_pc_o,
  output logic [DATA_WIDTH-1:0] branch_target_o,
  output logic                  take_branch_o,
  output logic                  flush_if_o,
  output logic                  flush_id_o,
  output logic                  halted_o
);

  pcc_state_e           state_q;
  logic [PCC_CNT_W-1:0] drain_cnt_q;
  logic                 halted_q;
  logic                 fetch_en, halt_go, arb_en, ex_evt, id_evt;

  assign fetch_en  = ~reset_i & (state_q == PCC_RUN || state_q == PCC_STEP)
                   & if_ready_i & ~stall_i;
  assign next_pc_o = fetch_en ? pc_i + DATA_WIDTH'(PC_INC) : pc_i;
  assign halt_go   = ~reset_i & (state_q == PCC_RUN) & halt_req_i;
  assign arb_en    = ~reset_i & (state_q != PCC_HALTED);

  // A HALT in ID squashes a same-cycle jump from that stage.
  pc_redirect_arb #(.W(DATA_WIDTH)) u_arb (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .enable_i        (arb_en),
    .if_ready_i      (if_ready_i),
    .stall_i         (stall_i),
    .ex_branch_i     (ex_branch_i),
    .ex_target_i     (ex_branch_target_i),
    .id_jump_i       (id_jump_i & ~halt_go),
    .id_target_i     (id_jump_target_i),
    .take_branch_o   (take_branch_o),
    .branch_target_o (branch_target_o),
    .ex_event_o      (ex_evt),
    .id_event_o      (id_evt)
  );

  assign flush_if_o = ex_evt | id_evt | halt_go;
  assign flush_id_o = ex_evt;
  assign halted_o   = halted_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= PCC_RUN;
      drain_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        PCC_RUN: begin
          if (halt_req_i) begin
            state_q     <= PCC_DRAIN;
            drain_cnt_q <= PCC_CNT_W'(DRAIN_CYCLES - 1);
          end
        end
        PCC_DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_q  <= PCC_HALTED;
            halted_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
          end
        end
        PCC_HALTED: begin
          if (dbg_resume_i) begin
            state_q  <= PCC_RUN;
            halted_q <= 1'b0;
          end else if (dbg_step_i) begin
            state_q  <= PCC_STEP;
            halted_q <= 1'b0;
          end
        end
        PCC_STEP: begin
          if (fetch_en) begin
            state_q     <= PCC_DRAIN;
            drain_cnt_q <= PCC_CNT_W'(DRAIN_CYCLES - 1);
          end
        end
        default: begin
          state_q  <= PCC_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Fetch-side controller that sequences the program counter register.
- Each cycle it drives the PC register's next_pc, branch_target and take_branch inputs.
- It arbitrates redirect requests from ID (jumps) and EX (resolved branches), and holds a redirect that arrives while the fetch port is not ready.
- It runs a halt/debug state machine (run, drain, halted, single-step) and generates the IF/ID flush strobes.

Parameters:
- DATA_WIDTH, 32, width of PC and targets (matches `DATA_WIDTH in mips_pkg.vh).
- PC_INC, 4, sequential fetch increment in bytes.
- DRAIN_CYCLES, 4, cycles spent in DRAIN so in-flight instructions retire before HALTED; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  DATA_WIDTH  current PC register value.
- if_ready  in  1  instruction memory can accept a fetch this cycle.
- stall  in  1  hazard-unit stall (load-use); freezes IF/ID.
- id_jump  in  1  ID stage decoded J/JAL/JR.
- id_jump_target  in  DATA_WIDTH  jump destination.
- ex_branch  in  1  EX stage resolved a taken branch.
- ex_branch_target  in  DATA_WIDTH  branch destination.
- halt_req  in  1  ID stage decoded HALT.
- dbg_step  in  1  one-cycle pulse: fetch a single instruction while halted.
- dbg_resume  in  1  one-cycle pulse: leave HALTED and return to RUN.
- next_pc  out  DATA_WIDTH  to PC.next_pc.
- branch_target  out  DATA_WIDTH  to PC.branch_target.
- take_branch  out  1  to PC.take_branch.
- flush_if  out  1  squash the IF/ID register contents.
- flush_id  out  1  squash the ID/EX register contents.
- halted  out  1  registered; high only in the HALTED state.

Behaviour:
- Reset: state=RUN, pend_valid=0, pend_target=0, pend_src=0, drain_cnt=0, halted=0.
  - While reset is high: take_branch=0, flush_if=0, flush_id=0, next_pc=pc.
- States:
  - RUN: normal fetch.
  - DRAIN: PC frozen while the pipeline empties; drain_cnt counts down.
  - HALTED: PC frozen.
  - STEP: exactly one fetch cycle.
- fetch_en = (state is RUN or STEP) & if_ready & ~stall.
  - next_pc = pc + PC_INC when fetch_en, else pc.
  - Addition wraps modulo 2^DATA_WIDTH.
- Redirect selection, highest priority first:
  - ex_branch: source EX, target ex_branch_target.
  - pend_valid: pending target.
  - id_jump: source ID, accepted only when ~stall.
  - ID jumps during stall are dropped; ID re-presents the jump next cycle.
- Redirect acceptance:
  - A selected redirect with if_ready=1: take_branch=1, branch_target=target, same cycle, so PC is updated at the next edge. pend_valid is cleared at that edge.
  - A selected redirect with if_ready=0: latched into pend_valid/pend_target/pend_src; take_branch=0.
  - Pending overwrite rules: ex_branch always overwrites pending. id_jump overwrites only when pend_valid=0 or pend_src=ID.
- Redirects are honoured in RUN, STEP and DRAIN, because in-flight branches must still steer resume.
  - In HALTED, redirect inputs are ignored and pending is kept.
  - The pending redirect is applied on the first if_ready cycle after RUN/STEP is re-entered.
- Flushes, combinational, coincident with the redirect event (whether applied or latched):
  - EX redirect: flush_if=1, flush_id=1.
  - ID redirect: flush_if=1 only.
  - Applying a pending redirect: no extra flush.
- HALT sequence:
  - RUN & halt_req: go to DRAIN; drain_cnt <= DRAIN_CYCLES-1; flush_if=1 that cycle; halt_req beats a same-cycle id_jump.
  - DRAIN: drain_cnt decrements each cycle; at 0 go to HALTED and halted<=1.
  - HALTED & dbg_resume: go to RUN, halted<=0.
  - HALTED & dbg_step (no resume): go to STEP, halted<=0.
  - dbg_resume and dbg_step together: resume wins.
  - STEP: if fetch_en, go to DRAIN with drain_cnt reload. If not, stay in STEP until the fetch occurs.
  - ex_branch in DRAIN: redirect is applied (PC moves); counter unaffected.
- Reset mid-operation (any state, pending set): returns to the reset values at the next edge.

Decomposition:
- mips_pkg.vh gains:
  - PCC_RUN=2'd0, PCC_DRAIN=2'd1, PCC_HALTED=2'd2, PCC_STEP=2'd3.
  - REDIR_ID=1'b0, REDIR_EX=1'b1.
  - `PC_INC default.
- One natural sub-module: pc_redirect_arb. It is combinational priority selection plus the pending register. The FSM and counter stay in pc_ctrl.

Test Plan:
- Sequential fetch: reset, then pc=0x100, if_ready=1 → next_pc=0x104, take_branch=0, flush_if=0. Then pc=0xFFFFFFFC → next_pc=0x00000000.
- Simultaneous redirect: id_jump(0x200) and ex_branch(0x300) same cycle, if_ready=1 → take_branch=1, branch_target=0x300, flush_if=flush_id=1. Then stall=1 with id_jump(0x200) → take_branch=0, flush_if=0.
- Pending hold: ex_branch(0x400) with if_ready=0 for 3 cycles → take_branch=0, flush_if=flush_id=1 on the request cycle. When if_ready rises → take_branch=1, branch_target=0x400 for one cycle, then pend_valid=0.
- Pending overwrite: pending ID 0x500 (if_ready=0), then ex_branch 0x600 → apply 0x600. Pending EX 0x600, then id_jump 0x700 → still 0x600.
- Halt/step/resume: halt_req at pc=0x20, DRAIN_CYCLES=4 → next_pc=pc for 4 cycles, halted=1 on the 5th. dbg_step → one next_pc=pc+4, back to HALTED after 4 more. dbg_resume → sequential fetch restarts.
- Reset mid-DRAIN with pending set → next cycle state RUN, halted=0, take_branch=0; a later if_ready does not apply the old target.
